// File: rtl/adpll_chan_seq.sv
// Channel sequencer for adpll_ctr: masters its CPU bus to disable, program FCW/MODE,
// enable, then poll LOCK; reports lock, lock loss and lock timeout.
module adpll_chan_seq #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FCW_W    = 26,
  parameter int unsigned A_FCW    = 0,
  parameter int unsigned A_MODE   = 1,
  parameter int unsigned A_EN     = 2,
  parameter int unsigned A_LOCK   = 3,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned LOCK_TO  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FCW_W-1:0]  req_fcw,
  input  logic [1:0]        req_mode,
  input  logic              abort,
  output logic              busy,
  output logic              locked,
  output logic              done,
  output logic              lock_lost,
  output logic              err_timeout,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wstrb,
  input  logic [1:0]        m_rdata,
  input  logic              m_ready
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(LOCK_TO);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DIS     = 4'd1;
  localparam logic [3:0] S_WR_FCW  = 4'd2;
  localparam logic [3:0] S_WR_MODE = 4'd3;
  localparam logic [3:0] S_WR_EN   = 4'd4;
  localparam logic [3:0] S_POLL_RD = 4'd5;
  localparam logic [3:0] S_PL_GAP  = 4'd6;
  localparam logic [3:0] S_LK_GAP  = 4'd7;
  localparam logic [3:0] S_LK_RD   = 4'd8;
  localparam logic [3:0] S_ABT     = 4'd9;
  localparam logic [3:0] S_ERR     = 4'd10;

  logic [3:0]        state_q, state_d;
  logic              en_flag_q, en_flag_d;
  logic [FCW_W-1:0]  fcw_q, fcw_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic              lost_q, lost_d;
  logic              err_q, err_d;
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_wstrb_q, m_wstrb_d;

  logic              xfer, accept, to_hit, abort_go, cfg_state;
  logic              iss, iss_wr;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;
  logic [CNT_W-1:0]  to_inc;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = m_rdata[1];

  assign xfer      = m_valid_q & m_ready;
  assign accept    = req_valid & rdy_q & ~abort;
  assign to_hit    = (to_cnt_q == TO_MAX);
  assign to_inc    = to_hit ? to_cnt_q : to_cnt_q + CNT_W'(1);
  assign cfg_state = (state_q == S_WR_FCW) || (state_q == S_WR_MODE) || (state_q == S_WR_EN);

  // Next-state, bus issue and status flag logic
  always_comb begin
    state_d   = state_q;
    en_flag_d = en_flag_q;
    fcw_d     = fcw_q;
    mode_d    = mode_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    locked_d  = locked_q;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    err_d     = err_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    iss       = 1'b0;
    iss_wr    = 1'b1;
    iss_addr  = '0;
    iss_data  = '0;
    abort_go  = 1'b0;
    busy_d    = 1'b0;
    rdy_d     = 1'b0;

    if (accept) begin
      fcw_d    = req_fcw;
      mode_d   = req_mode;
      err_d    = 1'b0;
      locked_d = 1'b0;
      state_d  = en_flag_q ? S_DIS : S_WR_FCW;
    end else begin
      case (state_q)
        S_DIS: begin
          if (xfer) begin
            en_flag_d = 1'b0;
            state_d   = S_WR_FCW;
          end else if (!m_valid_q) begin
            iss = 1'b1; iss_addr = ADDR_W'(A_EN); iss_data = '0;
          end
        end
        S_WR_FCW: begin
          if (xfer) state_d = S_WR_MODE;
          else if (!m_valid_q) begin
            iss = 1'b1; iss_addr = ADDR_W'(A_FCW); iss_data = DATA_W'(fcw_q);
          end
        end
        S_WR_MODE: begin
          if (xfer) state_d = S_WR_EN;
          else if (!m_valid_q) begin
            iss = 1'b1; iss_addr = ADDR_W'(A_MODE); iss_data = DATA_W'(mode_q);
          end
        end
        S_WR_EN: begin
          if (xfer) begin
            en_flag_d = 1'b1;
            to_cnt_d  = '0;
            state_d   = S_POLL_RD;
          end else if (!m_valid_q) begin
            iss = 1'b1; iss_addr = ADDR_W'(A_EN); iss_data = DATA_W'(1);
          end
        end
        S_POLL_RD: begin
          to_cnt_d = to_inc;
          // A lock read completing on the timeout cycle takes precedence
          if (xfer && m_rdata[0]) begin
            locked_d  = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = S_LK_GAP;
          end else if ((xfer || !m_valid_q) && to_hit) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (xfer) begin
            gap_cnt_d = '0;
            state_d   = S_PL_GAP;
          end else if (!m_valid_q) begin
            iss = 1'b1; iss_wr = 1'b0; iss_addr = ADDR_W'(A_LOCK);
          end
        end
        S_PL_GAP: begin
          to_cnt_d = to_inc;
          if (to_hit) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (gap_cnt_q == GAP_LAST) state_d = S_POLL_RD;
          else gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
        S_LK_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_d = S_LK_RD;
          else gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
        S_LK_RD: begin
          if (xfer) begin
            gap_cnt_d = '0;
            if (m_rdata[0]) state_d = S_LK_GAP;
            else begin
              locked_d = 1'b0;
              lost_d   = 1'b1;
              to_cnt_d = '0;
              state_d  = S_PL_GAP;
            end
          end else if (!m_valid_q) begin
            iss = 1'b1; iss_wr = 1'b0; iss_addr = ADDR_W'(A_LOCK);
          end
        end
        S_ABT: begin
          if (xfer) begin
            en_flag_d = 1'b0;
            state_d   = S_IDLE;
          end else if (!m_valid_q) begin
            iss = 1'b1; iss_addr = ADDR_W'(A_EN); iss_data = '0;
          end
        end
        default: ;
      endcase
    end

    // Abort once the bus is quiet; a partially programmed channel is also disabled
    abort_go = abort && (state_q != S_IDLE) && (state_q != S_ABT) && (!m_valid_q || xfer);
    if (abort_go) begin
      state_d   = (en_flag_d || cfg_state) ? S_ABT : S_IDLE;
      iss       = 1'b0;
      locked_d  = 1'b0;
      done_d    = 1'b0;
      lost_d    = 1'b0;
      err_d     = err_q;
      gap_cnt_d = '0;
    end

    if (iss) begin
      m_valid_d = 1'b1;
      m_addr_d  = iss_addr;
      m_wdata_d = iss_data;
      m_wstrb_d = iss_wr;
    end

    busy_d = !((state_d == S_IDLE) || (state_d == S_LK_GAP) ||
               (state_d == S_LK_RD) || (state_d == S_ERR));
    rdy_d  = !busy_d && !m_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      en_flag_q <= 1'b0;
      fcw_q     <= '0;
      mode_q    <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      lost_q    <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_flag_q <= en_flag_d;
      fcw_q     <= fcw_d;
      mode_q    <= mode_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  // Abort gates acceptance in the same cycle it is raised
  assign req_ready   = rdy_q & ~abort;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign done        = done_q;
  assign lock_lost   = lost_q;
  assign err_timeout = err_q;
  assign m_valid     = m_valid_q;
  assign m_address   = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;

endmodule

// File: tb/tb_adpll_chan_seq.sv
// Bench for adpll_chan_seq: reactive adpll_ctr bus model with random ready delays and a
// transaction-level model of the expected register write sequence per channel request.
module tb_adpll_chan_seq;

  localparam int FCW_W = 26, ADDR_W = 5, DATA_W = 32;
  localparam int POLL_GAP = 4, LOCK_TO = 200, MAX_D = 3;
  localparam int A_FCW = 0, A_MODE = 1, A_EN = 2, A_LOCK = 3;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, abort;
  logic [FCW_W-1:0] req_fcw;
  logic [1:0] req_mode, m_rdata;
  logic busy, locked, done, lock_lost, err_timeout, m_valid, m_wstrb, m_ready;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_wdata;

  adpll_chan_seq #(.POLL_GAP(POLL_GAP), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fcw(req_fcw), .req_mode(req_mode), .abort(abort), .busy(busy),
    .locked(locked), .done(done), .lock_lost(lock_lost), .err_timeout(err_timeout),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wr;
    logic        rb;
    int          cs;
  } xf_t;

  xf_t xlog[$];
  xf_t exp_q[$];
  bit  lock_q[$];
  bit  lock_dflt = 1'b1;
  bit  en_flag_m = 1'b0;
  int  hold_addr = -1, hold_delay = 0;
  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, done_cnt = 0, lost_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // Pulse counters
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (lock_lost) lost_cnt++;
  end

  // adpll_ctr bus slave: random ready latency, scripted LOCK responses
  initial begin
    xf_t cur;
    bit  in_x = 0;
    int  wcnt = 0;
    m_ready = 1'b0;
    m_rdata = 2'b00;
    cur = '{addr: '0, data: '0, wr: 1'b0, rb: 1'b0, cs: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_x = 0; m_ready = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0;
        xlog.push_back(cur);
        in_x = 0;
        check_eq("bus_gap", m_valid, 1'b0);
      end else if (m_valid) begin
        if (!in_x) begin
          in_x = 1;
          cur.addr = m_address; cur.data = m_wdata; cur.wr = m_wstrb; cur.rb = 1'b0; cur.cs = cyc;
          if (m_wstrb && int'(m_address) == hold_addr) begin
            wcnt = hold_delay; hold_addr = -1;
          end else wcnt = $urandom_range(0, MAX_D);
        end else
          check_eq("bus_stable", {m_address, m_wdata, m_wstrb}, {cur.addr, cur.data, cur.wr});
        if (wcnt == 0) begin
          m_ready = 1'b1;
          if (!cur.wr) begin
            cur.rb = (lock_q.size() > 0) ? lock_q.pop_front() : lock_dflt;
            m_rdata = {1'b0, cur.rb};
          end
        end else wcnt--;
      end else if (in_x) begin
        check_eq("bus_hold", m_valid, 1'b1);
        in_x = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic bit cond(input int w, input int arg);
    case (w)
      0: return done_cnt > arg;
      1: return lost_cnt > arg;
      2: return err_timeout;
      3: return m_valid && (int'(m_address) == arg);
      default: return !busy;
    endcase
  endfunction

  task automatic wait_cond(input int w, input int arg, input int budget, input string tag);
    int n = 0;
    while (!cond(w, arg) && n < budget) begin tick(1); n++; end
    check_eq({tag, "_seen"}, cond(w, arg), 1'b1);
  endtask

  task automatic do_req(input logic [FCW_W-1:0] f, input logic [1:0] md, output int idx);
    int n = 0;
    req_fcw = f; req_mode = md; req_valid = 1'b1;
    while (!req_ready && n < 500) begin tick(1); n++; end
    check_eq("req_accept", req_ready, 1'b1);
    @(posedge clk);
    tick(1);
    req_valid = 1'b0;
    idx = xlog.size();
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    xf_t e;
    e.addr = 5'(a); e.data = d; e.wr = 1'b1; e.rb = 1'b0; e.cs = 0;
    exp_q.push_back(e);
  endtask

  // Expected programming writes for a new channel given the believed enable state
  task automatic build_cfg(input logic [FCW_W-1:0] f, input logic [1:0] md);
    exp_q.delete();
    if (en_flag_m) push_exp(A_EN, 32'd0);
    push_exp(A_FCW, {6'b0, f});
    push_exp(A_MODE, {30'b0, md});
    push_exp(A_EN, 32'd1);
    en_flag_m = 1'b1;
  endtask

  task automatic check_log(input string tag, input int idx);
    check_eq({tag, "_len"}, (xlog.size() - idx) >= exp_q.size(), 1'b1);
    for (int i = 0; i < exp_q.size(); i++)
      if (idx + i < xlog.size())
        check_eq($sformatf("%s_x%0d", tag, i),
                 {xlog[idx+i].addr, xlog[idx+i].data, xlog[idx+i].wr},
                 {exp_q[i].addr, exp_q[i].data, exp_q[i].wr});
  endtask

  task automatic check_reads(input string tag, input int start, input int n_exp);
    int n = 0;
    logic last = 1'b0;
    for (int i = start; i < xlog.size(); i++) begin
      check_eq({tag, "_rd"}, {xlog[i].addr, xlog[i].wr}, {5'(A_LOCK), 1'b0});
      n++; last = xlog[i].rb;
    end
    check_eq({tag, "_nrd"}, n, n_exp);
    check_eq({tag, "_lastrd"}, last, 1'b1);
  endtask

  // Program a channel, let it lock after nz failed polls, and check the whole sequence
  task automatic tune(input string tag, input logic [FCW_W-1:0] f, input logic [1:0] md);
    int idx, d0, nz, nw;
    build_cfg(f, md);
    nw = exp_q.size();
    d0 = done_cnt;
    do_req(f, md, idx);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_lockdrop"}, locked, 1'b0);
    nz = $urandom_range(0, 3);
    repeat (nz) lock_q.push_back(1'b0);
    wait_cond(0, d0, 2000, {tag, "_done"});
    tick(2);
    check_log(tag, idx);
    check_reads(tag, idx + nw, nz + 1);
    check_eq({tag, "_locked"}, locked, 1'b1);
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_done1"}, done_cnt - d0, 1);
  endtask

  initial begin
    int idx, d0, l0, e, diff, nsz, k;
    logic [FCW_W-1:0] f;
    logic [1:0] md;
    rst = 1'b0; req_valid = 1'b0; req_fcw = '0; req_mode = '0; abort = 1'b0;
    tick(3);
    check_eq("rst_outs", {req_ready, busy, locked, done, lock_lost, err_timeout, m_valid, m_wstrb}, 8'h00);
    check_eq("rst_bus", {m_address, m_wdata}, '0);
    rst = 1'b1;
    tick(2);
    check_eq("rst_ready", req_ready, 1'b1);

    // First channel from reset: no disable write
    tune("s1", 26'd39354368, 2'd1);

    // Lock loss while locked, then relock
    for (int it = 0; it < 2; it++) begin
      l0 = lost_cnt; d0 = done_cnt;
      k = $urandom_range(1, 3);
      repeat (k) lock_q.push_back(1'b0);
      wait_cond(1, l0, 500, "loss");
      check_eq("loss_unlocked", locked, 1'b0);
      wait_cond(0, d0, 1000, "relock");
      tick(3);
      check_eq("relock_locked", locked, 1'b1);
      check_eq("loss_pulse1", lost_cnt - l0, 1);
      check_eq("relock_done1", done_cnt - d0, 1);
    end

    // Retunes from locked always disable first
    for (int it = 0; it < 3; it++) begin
      f = (it == 0) ? 26'd39419904 : FCW_W'($urandom);
      md = 2'($urandom_range(0, 3));
      tune($sformatf("rt%0d", it), f, md);
    end

    // Lock never reported: timeout into ERR
    f = FCW_W'($urandom);
    build_cfg(f, 2'd2);
    do_req(f, 2'd2, idx);
    lock_dflt = 1'b0;
    wait_cond(2, 0, 3000, "to");
    e = cyc;
    check_log("to", idx);
    diff = (xlog.size() > idx + 4) ? (e - xlog[idx+4].cs) : -1;
    check_eq("to_window", (diff >= LOCK_TO) && (diff <= LOCK_TO + MAX_D + 2), 1'b1);
    check_eq("to_state", {busy, locked, req_ready}, 3'b001);
    nsz = xlog.size();
    tick(20);
    check_eq("to_sticky", err_timeout, 1'b1);
    check_eq("to_quiet", xlog.size() - nsz, 0);
    lock_dflt = 1'b1;
    d0 = done_cnt;
    do_req(f, 2'd3, idx);
    check_eq("to_clear", err_timeout, 1'b0);
    build_cfg(f, 2'd3);
    exp_q[0].addr = 5'(A_EN);
    wait_cond(0, d0, 2000, "to_rec");
    tick(2);
    check_log("to_rec", idx);

    // Abort during MODE write with delayed ready
    f = FCW_W'($urandom);
    md = 2'($urandom_range(0, 3));
    exp_q.delete();
    push_exp(A_EN, 32'd0); push_exp(A_FCW, {6'b0, f}); push_exp(A_MODE, {30'b0, md}); push_exp(A_EN, 32'd0);
    en_flag_m = 1'b0;
    hold_addr = A_MODE; hold_delay = 3;
    d0 = done_cnt;
    do_req(f, md, idx);
    wait_cond(3, A_MODE, 200, "ab_mode");
    abort = 1'b1;
    wait_cond(4, 0, 200, "ab_idle");
    tick(2);
    check_log("ab", idx);
    check_eq("ab_count", xlog.size() - idx, 4);
    check_eq("ab_state", {locked, req_ready, busy}, 3'b000);
    check_eq("ab_nodone", done_cnt - d0, 0);
    nsz = xlog.size();
    req_valid = 1'b1;
    tick(3);
    check_eq("ab_wins", {busy, m_valid}, 2'b00);
    check_eq("ab_noxfer", xlog.size() - nsz, 0);
    req_valid = 1'b0; abort = 1'b0;
    tick(1);
    check_eq("ab_ready", req_ready, 1'b1);
    tune("ab_new", FCW_W'($urandom), 2'($urandom_range(0, 3)));

    // Reset in the middle of a LOCK poll
    lock_dflt = 1'b1;
    do_req(FCW_W'($urandom), 2'd1, idx);
    lock_dflt = 1'b0;
    wait_cond(3, A_LOCK, 500, "rp_poll");
    rst = 1'b0;
    #1;
    check_eq("rp_outs", {req_ready, busy, locked, done, lock_lost, err_timeout, m_valid}, 7'h00);
    lock_q.delete();
    tick(3);
    rst = 1'b1;
    en_flag_m = 1'b0;
    lock_dflt = 1'b1;
    tick(2);
    check_eq("rp_ready", req_ready, 1'b1);
    tune("rp_new", FCW_W'($urandom), 2'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
